// File: rtl/mem_access.sv
// MEM stage of a 5-stage pipeline: drives the data memory port with wait-state
// handling, resolves branch/jump redirects, and produces the MEM/WB register.
module mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_Branch_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic        Zero_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] PCimm_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  Rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        PCSrc_out,
  output logic        flush_out,
  output logic [31:0] PCtarget_out,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic [4:0]  Rd_out,
  output logic        mem_err_out
);

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic [1:0] { WB_BUBBLE, WB_INPUT, WB_HELD } wb_sel_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  wb_sel_t     wb_sel;
  logic        latch, err_set, capture;
  logic        mem_op, aligned;
  logic [31:0] link;

  // Copies of the EX/MEM operation held while the memory inserts wait states.
  logic        held_memtoreg, held_regwrite, held_memread, held_we;
  logic [31:0] held_addr, held_wdata, held_alu;
  logic [4:0]  held_rd;

  assign mem_op       = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign aligned      = (ALUresult_in[1:0] == 2'b00);
  assign link         = (jal_in | jalr_in) ? (PC_in + 32'd4) : ALUresult_in;
  assign PCtarget_out = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;
  assign flush_out    = PCSrc_out;

  // State and wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, memory port, stall/redirect and MEM/WB load selection.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = {ALUresult_in[31:2], 2'b00};
    dmem_wdata = ReadData2_in;
    stall_out  = 1'b0;
    PCSrc_out  = 1'b0;
    wb_sel     = WB_BUBBLE;
    latch      = 1'b0;
    err_set    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        PCSrc_out = (Ctl_Branch_in & Zero_in) | jal_in | jalr_in;
        if (mem_op) begin
          if (aligned) begin
            dmem_req = 1'b1;
            dmem_we  = Ctl_MemWrite_in;
            if (dmem_ready) begin
              wb_sel  = WB_INPUT;
              capture = Ctl_MemRead_in;
            end else begin
              stall_out = 1'b1;
              latch     = 1'b1;
              cnt_nxt   = 8'd1;
              state_nxt = WAIT;
            end
          end else begin
            err_set = 1'b1;
          end
        end else begin
          wb_sel = WB_INPUT;
        end
      end
      WAIT: begin
        dmem_req   = 1'b1;
        stall_out  = 1'b1;
        dmem_we    = held_we;
        dmem_addr  = held_addr;
        dmem_wdata = held_wdata;
        if (dmem_ready) begin
          wb_sel    = WB_HELD;
          capture   = held_memread;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (cnt == MAX_W) begin
          err_set   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The memory port and stall must release the instant reset asserts.
    if (!reset) begin
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      stall_out = 1'b0;
      PCSrc_out = 1'b0;
    end
  end

  // Capture the EX/MEM operation when a request enters wait states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_memtoreg <= 1'b0;
      held_regwrite <= 1'b0;
      held_memread  <= 1'b0;
      held_we       <= 1'b0;
      held_addr     <= 32'd0;
      held_wdata    <= 32'd0;
      held_alu      <= 32'd0;
      held_rd       <= 5'd0;
    end else if (latch) begin
      held_memtoreg <= Ctl_MemtoReg_in;
      held_regwrite <= Ctl_RegWrite_in;
      held_memread  <= Ctl_MemRead_in;
      held_we       <= Ctl_MemWrite_in;
      held_addr     <= {ALUresult_in[31:2], 2'b00};
      held_wdata    <= ReadData2_in;
      held_alu      <= link;
      held_rd       <= Rd_in;
    end
  end

  // MEM/WB register and sticky error flag; bubbles keep the data fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      ReadData_out     <= 32'd0;
      ALUresult_out    <= 32'd0;
      Rd_out           <= 5'd0;
      mem_err_out      <= 1'b0;
    end else begin
      if (err_set) mem_err_out <= 1'b1;
      if (capture) ReadData_out <= dmem_rdata;
      case (wb_sel)
        WB_INPUT: begin
          Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
          Ctl_RegWrite_out <= Ctl_RegWrite_in;
          ALUresult_out    <= link;
          Rd_out           <= Rd_in;
        end
        WB_HELD: begin
          Ctl_MemtoReg_out <= held_memtoreg;
          Ctl_RegWrite_out <= held_regwrite;
          ALUresult_out    <= held_alu;
          Rd_out           <= held_rd;
        end
        default: begin
          Ctl_MemtoReg_out <= 1'b0;
          Ctl_RegWrite_out <= 1'b0;
          Rd_out           <= 5'd0;
        end
      endcase
    end
  end

endmodule
